uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
- Serial-to-parallel receive stage for the APB UART; consumes the serial line produced by the transmit stage (loopback or external pad).
- Shares the transmit stage's config encoding: cfg_div, bits, parity select, stop bits.
- Recovers characters by mid-bit sampling and delivers them over a valid/ready byte interface to the RX FIFO / register block.
- Flags parity, framing and overrun errors.

Parameters:
SYNC_STAGES, 2, number of flops synchronising rx_i into clk_i domain (min 2)

Ports:
clk_i  input  1  single clock; all logic on rising edge
rst_i  input  1  asynchronous, active-high reset
rx_i  input  1  serial line, idle high, asynchronous to clk_i
busy_o  output  1  high whenever state != IDLE
cfg_en_i  input  1  receiver enable
cfg_div_i  input  16  bit period = cfg_div_i+1 clocks
cfg_parity_en_i  input  1  parity bit present
cfg_parity_sel_i  input  2  00 odd, 01 even, 10 space (0), 11 mark (1)
cfg_bits_i  input  2  00=8, 01=7, 10=6, 11=5 data bits
cfg_stop_bits_i  input  1  0=1 stop, 1=2 stop (only the first is checked)
rx_data_o  output  8  received char, LSB first on line, unused MSBs zero
rx_valid_o  output  1  char available; held until accepted
rx_ready_i  input  1  consumer accepts when rx_valid_o & rx_ready_i
err_parity_o  output  1  one-cycle pulse, parity mismatch
err_frame_o  output  1  one-cycle pulse, stop bit sampled 0
err_overrun_o  output  1  one-cycle pulse, char dropped because rx_valid_o still high

Behaviour:
- Reset values: synchroniser flops 1, state IDLE, rx_data_o 0, rx_valid_o 0, all err_* 0, busy_o 0, counters 0.
- Synchroniser: rx_s = rx_i delayed SYNC_STAGES clocks; all decisions use rx_s only.
- Baud counter: cleared in IDLE; otherwise counts 0..cfg_div_i, wraps to 0. Sample strobe when count == cfg_div_i>>1 (mid-bit).
- States:
  - IDLE -> START on rx_s == 0, but only if cfg_en_i == 1.
  - START: at sample, rx_s == 1 -> IDLE (false start, no output, no error); else -> DATA, bit index 0.
  - DATA: at each sample, shift rx_s in LSB first and accumulate XOR. After target bit count (5..8) -> PARITY if cfg_parity_en_i, else STOP.
  - PARITY: at sample, compare rx_s with expected:
    - 00: ~xor
    - 01: xor
    - 10: 0
    - 11: 1
    - Mismatch latched internally. -> STOP.
  - STOP: at sample, complete the character -> IDLE. The second stop bit is not waited for; an immediate start edge is accepted.
- Completion (the cycle after the stop sample):
  - Data right-aligned, upper bits zero.
  - If rx_valid_o == 0, or rx_valid_o & rx_ready_i in that same cycle: load rx_data_o, set rx_valid_o.
  - Otherwise pulse err_overrun_o; rx_data_o unchanged.
  - err_parity_o pulses with the completion when a parity mismatch was latched.
  - err_frame_o pulses with the completion when the stop sample was 0.
  - Both error pulses fire even if the char is dropped.
- Handshake: rx_valid_o clears on rx_valid_o & rx_ready_i unless a new char loads in the same cycle, in which case it stays 1 with the new data.
- cfg_en_i low: state forced to IDLE next clock, counters cleared, rx_valid_o cleared, no error pulses.
- Config is sampled live; software changes it only while busy_o == 0.
- cfg_div_i == 0: sample every clock, strobe at count 0; must still function (1 clock/bit).

Test Plan:
- div=3, 8N1, send 0xA5 (LSB first) with rx_ready_i=1 -> rx_valid_o high one cycle, rx_data_o=0xA5, no errors, busy_o low after stop sample.
- div=7, 7 bits, even parity, send 0x55 then the same frame with parity flipped -> first: data 0x55, no error; second: data 0x55, err_parity_o pulse.
- div=3, 5 bits, no parity, send 0x1F with stop bit forced 0 -> rx_data_o=0x1F, err_frame_o one pulse.
- rx_ready_i=0, send 0x11 then 0x22 back-to-back -> rx_data_o stays 0x11 with rx_valid_o held, err_overrun_o pulse at second completion; raise ready -> valid clears.
- 2-clock low glitch on rx_i with div=7 -> returns to IDLE, no valid, no errors.
- Drop cfg_en_i mid-DATA, re-enable, send 0x3C -> partial frame discarded, next output 0x3C; assert rst_i mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: synchronises rx_i, samples each bit mid-period,
// and hands characters plus parity/frame/overrun flags to a valid/ready consumer.
`timescale 1ns/1ps
module uart_rx_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  output logic        busy_o,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_parity_sel_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        err_overrun_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [15:0]            cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   xor_q, xor_d;
  logic                   perr_q, perr_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_par_q, err_par_d;
  logic                   err_frm_q, err_frm_d;
  logic                   err_ovr_q, err_ovr_d;

  logic                   rx_s;
  logic                   strobe;
  logic [15:0]            cnt_inc;
  logic [2:0]             last_bit;
  logic                   exp_par;
  logic                   unused_stop_bits;

  // The receiver never waits for a second stop bit, so this setting has no effect here.
  assign unused_stop_bits = cfg_stop_bits_i;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign cnt_inc  = (cnt_q == cfg_div_i) ? 16'd0 : cnt_q + 16'd1;
  assign strobe   = (cnt_q == (cfg_div_i >> 1));
  assign last_bit = 3'd7 - {1'b0, cfg_bits_i};

  always_comb begin
    exp_par = 1'b1;
    case (cfg_parity_sel_i)
      2'b00:   exp_par = ~xor_q;
      2'b01:   exp_par = xor_q;
      2'b10:   exp_par = 1'b0;
      default: exp_par = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    bit_d     = bit_q;
    shift_d   = shift_q;
    xor_d     = xor_q;
    perr_d    = perr_q;
    data_d    = data_q;
    valid_d   = valid_q & ~rx_ready_i;
    err_par_d = 1'b0;
    err_frm_d = 1'b0;
    err_ovr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cfg_en_i && !rx_s) begin
          // The detection cycle is count 0 of the start bit; with div<2 it is also its sample.
          cnt_d   = cnt_inc;
          bit_d   = '0;
          shift_d = '0;
          xor_d   = 1'b0;
          perr_d  = 1'b0;
          state_d = strobe ? S_DATA : S_START;
        end
      end
      S_START: begin
        if (strobe) begin
          if (rx_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (strobe) begin
          shift_d[bit_q] = rx_s;
          xor_d          = xor_q ^ rx_s;
          bit_d          = bit_q + 3'd1;
          if (bit_q == last_bit)
            state_d = cfg_parity_en_i ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (strobe) begin
          perr_d  = (rx_s != exp_par);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (strobe) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          err_par_d = perr_q;
          err_frm_d = ~rx_s;
          // A char may load into a slot that is being emptied this same cycle.
          if (!valid_q || rx_ready_i) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_ovr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!cfg_en_i) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      valid_d   = 1'b0;
      err_par_d = 1'b0;
      err_frm_d = 1'b0;
      err_ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= '1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      xor_q     <= 1'b0;
      perr_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      xor_q     <= xor_d;
      perr_q    <= perr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_par_q <= err_par_d;
      err_frm_q <= err_frm_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign err_parity_o  = err_par_q;
  assign err_frame_o   = err_frm_q;
  assign err_overrun_o = err_ovr_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: a table of hand-computed frames, randomized bursts
// against a frame-level model, and hand sequences for overrun, glitch, enable and reset.
`timescale 1ns/1ps
module tb_uart_rx_deser;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_i;
  logic        busy_o;
  logic        cfg_en_i;
  logic [15:0] cfg_div_i;
  logic        cfg_parity_en_i;
  logic [1:0]  cfg_parity_sel_i;
  logic [1:0]  cfg_bits_i;
  logic        cfg_stop_bits_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        err_parity_o;
  logic        err_frame_o;
  logic        err_overrun_o;

  uart_rx_deser #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .busy_o(busy_o),
    .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i), .cfg_parity_en_i(cfg_parity_en_i),
    .cfg_parity_sel_i(cfg_parity_sel_i), .cfg_bits_i(cfg_bits_i),
    .cfg_stop_bits_i(cfg_stop_bits_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .err_parity_o(err_parity_o), .err_frame_o(err_frame_o),
    .err_overrun_o(err_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         div;
    logic [1:0] bits;
    logic       pen;
    logic [1:0] psel;
    logic       pbit;
    logic       stop2;
    logic       stop_v;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
  } obs_t;

  int   n_vec = 0;
  int   n_miss = 0;
  int   stray_cnt = 0;
  int   ovr_cnt = 0;
  obs_t got_q[$];
  obs_t exp_q[$];
  vec_t tbl[10];

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rx_valid_o && rx_ready_i) got_q.push_back('{rx_data_o, err_parity_o, err_frame_o});
      if ((err_parity_o || err_frame_o) && !rx_valid_o) stray_cnt++;
      if (err_overrun_o) ovr_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int div, input logic [1:0] bits, input logic pen,
                         input logic [1:0] psel, input logic stop2);
    cfg_div_i        = 16'(div);
    cfg_bits_i       = bits;
    cfg_parity_en_i  = pen;
    cfg_parity_sel_i = psel;
    cfg_stop_bits_i  = stop2;
  endtask

  // A forced-low stop bit is held only past its mid-bit sample, then released,
  // so the tail of the bad stop bit is not mistaken for a new start edge.
  task automatic send_frame(input int div, input int nbits, input logic pen, input logic pbit,
                            input logic stop2, input logic stop_v, input logic [7:0] data);
    int per = div + 1;
    rx_i = 1'b0;
    repeat (per) tick();
    for (int i = 0; i < nbits; i++) begin
      rx_i = data[i];
      repeat (per) tick();
    end
    if (pen) begin
      rx_i = pbit;
      repeat (per) tick();
    end
    if (stop_v) begin
      rx_i = 1'b1;
      repeat (per) tick();
    end else begin
      rx_i = 1'b0;
      repeat (div / 2 + 1) tick();
      rx_i = 1'b1;
      repeat (per - div / 2 - 1) tick();
    end
    if (stop2) begin
      rx_i = 1'b1;
      repeat (per) tick();
    end
  endtask

  function automatic logic rule_par(input logic [7:0] d, input int n, input logic [1:0] sel);
    int ones = $countones(d & 8'((1 << n) - 1));
    case (sel)
      2'b00:   return (ones % 2) == 0;
      2'b01:   return (ones % 2) == 1;
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    obs_t o;
    set_cfg(v.div, v.bits, v.pen, v.psel, v.stop2);
    got_q.delete();
    send_frame(v.div, 8 - int'(v.bits), v.pen, v.pbit, v.stop2, v.stop_v, v.data);
    repeat ((v.div + 1) * 2 + 6) tick();
    chk($sformatf("vec%0d count", idx), got_q.size(), 1);
    if (got_q.size() > 0) begin
      o = got_q[0];
      chk($sformatf("vec%0d data", idx), o.d, v.exp_data);
      chk($sformatf("vec%0d perr", idx), o.p, v.exp_perr);
      chk($sformatf("vec%0d ferr", idx), o.f, v.exp_ferr);
      $display("vec %0d: div=%0d sent=%h got=%h perr=%0d ferr=%0d", idx, v.div, v.data, o.d, o.p, o.f);
    end
    chk($sformatf("vec%0d busy", idx), busy_o, 0);
  endtask

  initial begin
    tbl[0] = '{3, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{7, 2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 8'h55, 8'h55, 1'b0, 1'b0};
    tbl[2] = '{7, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h55, 8'h55, 1'b1, 1'b0};
    tbl[3] = '{3, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h1F, 8'h1F, 1'b0, 1'b1};
    tbl[4] = '{0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0};
    tbl[5] = '{1, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h3F, 1'b0, 1'b0};
    tbl[6] = '{2, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 8'h81, 8'h81, 1'b1, 1'b0};
    tbl[7] = '{5, 2'b01, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h7F, 1'b0, 1'b0};
    tbl[8] = '{4, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h16, 8'h16, 1'b0, 1'b1};
    tbl[9] = '{0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h0A, 8'h0A, 1'b1, 1'b1};

    rst_i = 1'b1; rx_i = 1'b1; cfg_en_i = 1'b1; rx_ready_i = 1'b1;
    set_cfg(3, 2'b00, 1'b0, 2'b00, 1'b0);
    repeat (3) tick();
    chk("reset valid", rx_valid_o, 0);
    chk("reset data", rx_data_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset errs", {err_parity_o, err_frame_o, err_overrun_o}, 0);
    rst_i = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Randomized bursts of back-to-back frames; config only changes between bursts.
    for (int b = 0; b < 8; b++) begin
      int         div   = $urandom_range(0, 12);
      logic [1:0] bits  = 2'($urandom_range(0, 3));
      logic       pen   = 1'($urandom_range(0, 1));
      logic [1:0] psel  = 2'($urandom_range(0, 3));
      logic       stop2 = 1'($urandom_range(0, 1));
      int         nb    = 8 - int'(bits);
      set_cfg(div, bits, pen, psel, stop2);
      got_q.delete();
      exp_q.delete();
      for (int f = 0; f < 4; f++) begin
        logic [7:0] d     = 8'($urandom);
        logic       pbit  = 1'($urandom_range(0, 1));
        logic       stopv = ($urandom_range(0, 3) != 0);
        exp_q.push_back('{d & 8'((1 << nb) - 1), pen && (pbit != rule_par(d, nb, psel)), !stopv});
        send_frame(div, nb, pen, pbit, stop2, stopv, d);
      end
      repeat ((div + 1) * 2 + 6) tick();
      chk($sformatf("burst%0d count", b), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i < got_q.size()) begin
          chk($sformatf("burst%0d.%0d data", b, i), got_q[i].d, exp_q[i].d);
          chk($sformatf("burst%0d.%0d perr", b, i), got_q[i].p, exp_q[i].p);
          chk($sformatf("burst%0d.%0d ferr", b, i), got_q[i].f, exp_q[i].f);
          $display("burst %0d frame %0d: div=%0d exp=%h got=%h", b, i, div, exp_q[i].d, got_q[i].d);
        end
      end
    end
    chk("random overruns", ovr_cnt, 0);

    // Overrun: consumer stalled, second char dropped.
    set_cfg(3, 2'b00, 1'b0, 2'b00, 1'b0);
    rx_ready_i = 1'b0;
    ovr_cnt = 0;
    send_frame(3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    send_frame(3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
    repeat (16) tick();
    chk("ovr data", rx_data_o, 8'h11);
    chk("ovr valid", rx_valid_o, 1);
    chk("ovr pulses", ovr_cnt, 1);
    rx_ready_i = 1'b1;
    tick();
    chk("ovr valid clears", rx_valid_o, 0);
    $display("overrun: held=%h pulses=%0d", rx_data_o, ovr_cnt);

    // Two-clock glitch is a false start.
    set_cfg(7, 2'b00, 1'b0, 2'b00, 1'b0);
    got_q.delete();
    stray_cnt = 0;
    rx_i = 1'b0;
    repeat (2) tick();
    rx_i = 1'b1;
    repeat (30) tick();
    chk("glitch chars", got_q.size(), 0);
    chk("glitch errs", stray_cnt, 0);
    chk("glitch busy", busy_o, 0);
    $display("glitch: chars=%0d busy=%0d", got_q.size(), busy_o);

    // Enable dropped mid-DATA discards the partial frame and the held char.
    set_cfg(3, 2'b00, 1'b0, 2'b00, 1'b0);
    rx_ready_i = 1'b0;
    send_frame(3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
    repeat (12) tick();
    chk("en held valid", rx_valid_o, 1);
    rx_i = 1'b0; repeat (4) tick();
    rx_i = 1'b1; repeat (4) tick();
    rx_i = 1'b0; repeat (4) tick();
    rx_i = 1'b1; repeat (4) tick();
    chk("en busy mid-data", busy_o, 1);
    cfg_en_i = 1'b0;
    tick();
    chk("en off busy", busy_o, 0);
    chk("en off valid", rx_valid_o, 0);
    rx_i = 1'b1;
    repeat (8) tick();
    cfg_en_i = 1'b1;
    rx_ready_i = 1'b1;
    got_q.delete();
    send_frame(3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
    repeat (14) tick();
    chk("en re count", got_q.size(), 1);
    if (got_q.size() > 0) chk("en re data", got_q[0].d, 8'h3C);
    $display("enable: chars after re-enable=%0d", got_q.size());

    // Asynchronous reset mid-frame clears outputs without waiting for a clock edge.
    rx_ready_i = 1'b0;
    send_frame(3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77);
    repeat (12) tick();
    chk("rst pre data", rx_data_o, 8'h77);
    rx_i = 1'b0; repeat (4) tick();
    rx_i = 1'b1; repeat (6) tick();
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst async data", rx_data_o, 0);
    chk("rst async valid", rx_valid_o, 0);
    chk("rst async busy", busy_o, 0);
    $display("reset mid-frame: data=%h valid=%0d busy=%0d", rx_data_o, rx_valid_o, busy_o);
    tick();
    rst_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
